fir_coeff_loader: RTL and testbench

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

---
 rtl/fir_coeff_loader.sv | 117 +++++++++++
 tb/tb_fir_coeff_loader.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Byte-serial loader for a 7-tap FIR coefficient set: parses HEADER/MODE/14 coef/CHK
// frames into a shadow register and commits coefficients plus enable atomically on a good checksum.
module fir_coeff_loader #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter logic [15:0] TIMEOUT = 16'd50000,
  localparam int DATA_W = 8,
  localparam int COEF_W = 16,
  localparam int EFF_W  = 7 * COEF_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [EFF_W-1:0]  eff,
  output logic              en,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [1:0] {S_IDLE, S_MODE, S_COEF, S_CHECK} state_t;

  localparam logic [3:0] LAST_IDX = 4'd13;

  state_t             state, state_nxt;
  logic [3:0]         byte_cnt;
  logic [EFF_W-1:0]   shadow;
  logic               shadow_mode;
  logic [DATA_W-1:0]  chk;
  logic [15:0]        tmo_cnt;
  logic               tmo_hit;
  logic               hdr_hit;
  logic               commit_p0;
  logic               fail_p0;
  logic [6:0]         byte_lsb;

  assign hdr_hit  = (state == S_IDLE) && rx_valid && (rx_data == HEADER);
  assign tmo_hit  = (state != S_IDLE) && !rx_valid && (tmo_cnt == TIMEOUT - 16'd1);
  // coeff1 high byte lands at the top of the shadow, coeff7 low byte at the bottom
  assign byte_lsb = {LAST_IDX - byte_cnt, 3'b000};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (hdr_hit) state_nxt = S_MODE;
      S_MODE:  if (rx_valid) state_nxt = S_COEF;
               else if (tmo_hit) state_nxt = S_IDLE;
      S_COEF:  if (rx_valid && byte_cnt == LAST_IDX) state_nxt = S_CHECK;
               else if (tmo_hit) state_nxt = S_IDLE;
      S_CHECK: if (rx_valid || tmo_hit) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    commit_p0 = (state == S_CHECK) && rx_valid && (rx_data == chk);
    fail_p0   = ((state == S_CHECK) && rx_valid && (rx_data != chk)) || tmo_hit;
  end

  // frame capture: shadow, checksum, byte index and inter-byte timeout
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow      <= '0;
      shadow_mode <= 1'b0;
      chk         <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      if (state == S_IDLE || rx_valid || tmo_hit) tmo_cnt <= '0;
      else                                        tmo_cnt <= tmo_cnt + 16'd1;

      if (hdr_hit || tmo_hit) begin
        shadow      <= '0;
        shadow_mode <= 1'b0;
        chk         <= '0;
        byte_cnt    <= '0;
      end else if (rx_valid) begin
        case (state)
          S_MODE: begin
            shadow_mode <= rx_data[0];
            chk         <= rx_data;
          end
          S_COEF: begin
            shadow[byte_lsb +: 8] <= rx_data;
            chk                   <= chk ^ rx_data;
            byte_cnt              <= (byte_cnt == LAST_IDX) ? 4'd0 : byte_cnt + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // commit stage: outputs only move on a verified frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eff       <= '0;
      en        <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      load_done <= commit_p0;
      load_err  <= fail_p0;
      if (commit_p0) begin
        eff <= shadow;
        en  <= shadow_mode;
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Randomized directed bench for fir_coeff_loader; the model tracks committed
// coefficients/enable per frame outcome and checksums frames with a plain XOR loop.
module tb_fir_coeff_loader;

  localparam logic [7:0] HDR = 8'hA5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [111:0] eff;
  logic         en;
  logic         busy;
  logic         load_done;
  logic         load_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [111:0] exp_eff = '0;
  logic         exp_en  = 1'b0;

  fir_coeff_loader #(.HEADER(HDR), .TIMEOUT(16'd16)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .eff(eff), .en(en), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [111:0] obs, input logic [111:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; presents one byte for exactly one cycle.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_frame(input logic [7:0] mode, input logic [111:0] coef, input logic bad,
                           input int maxgap, input int long_gap_at, input string tag);
    logic [7:0] fb [17];
    logic [7:0] x;
    fb[0] = HDR;
    fb[1] = mode;
    for (int i = 0; i < 14; i++) fb[2+i] = coef[111-8*i -: 8];
    x = 8'h00;
    for (int i = 1; i <= 15; i++) x = x ^ fb[i];
    fb[16] = bad ? ~x : x;
    for (int i = 0; i < 17; i++) begin
      send(fb[i]);
      if (i == 0) begin
        check({tag, "_busy_rise"}, busy, 1);
        check({tag, "_no_pulse"}, {load_done, load_err}, 0);
      end
      if (i == 9) check({tag, "_eff_hold"}, {eff, en}, {exp_eff, exp_en});
      if (i < 16) begin
        if (i == long_gap_at) idle(15);
        else if (maxgap > 0) idle($urandom_range(0, maxgap));
      end
    end
    if (!bad) begin
      exp_eff = coef;
      exp_en  = mode[0];
    end
    check({tag, "_done"}, load_done, !bad);
    check({tag, "_err"}, load_err, bad);
    check({tag, "_busy_fall"}, busy, 0);
    check({tag, "_eff"}, eff, exp_eff);
    check({tag, "_en"}, en, exp_en);
  endtask

  function automatic logic [111:0] rnd_coef();
    return {$urandom, $urandom, $urandom, 16'($urandom)};
  endfunction

  initial begin
    logic [111:0] c;
    int k_hit;
    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check("rst_outputs", {eff, en, busy, load_done, load_err}, 0);
    reset_n = 1'b1;
    idle(1);

    run_frame(8'h01, 112'h0000_8000_1234_4000_1234_8000_0000, 1'b0, 0, -1, "ref_frame");
    check("ref_literal", eff, 112'h0000_8000_1234_4000_1234_8000_0000);
    idle(1);
    check("ref_pulse_once", {load_done, load_err}, 0);

    run_frame(8'h01, 112'h0000_8000_1234_4000_1234_8000_0000, 1'b1, 0, -1, "bad_chk");
    idle(1);
    check("bad_pulse_once", {load_done, load_err}, 0);

    send(8'h00); check("junk00", {busy, load_done, load_err}, 0);
    send(8'h5A); check("junk5A", {busy, load_done, load_err}, 0);
    send(8'hFF); check("junkFF", {busy, load_done, load_err}, 0);
    run_frame(8'($urandom), rnd_coef(), 1'b0, 2, -1, "after_junk");

    c = rnd_coef();
    send(HDR);
    send(8'h01);
    for (int i = 0; i < 8; i++) send(c[111-8*i -: 8]);
    k_hit = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (load_err) begin
        k_hit = k;
        break;
      end
    end
    check("tmo_latency", 112'(k_hit), 16);
    check("tmo_no_done", load_done, 0);
    check("tmo_busy", busy, 0);
    check("tmo_eff_kept", {eff, en}, {exp_eff, exp_en});
    run_frame(8'h00, rnd_coef(), 1'b0, 0, -1, "after_tmo");

    c = rnd_coef();
    c[79:72] = HDR;
    run_frame(8'h01, c, 1'b0, 0, -1, "hdr_as_data");
    check("hdr_byte5", 112'(eff[79:72]), 112'(HDR));

    c = rnd_coef();
    send(HDR);
    send(8'h01);
    for (int i = 0; i < 7; i++) send(c[111-8*i -: 8]);
    rx_data  = c[55:48];
    rx_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    exp_eff = '0;
    exp_en  = 1'b0;
    check("midrst_outputs", {eff, en, busy, load_done, load_err}, 0);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    check("midrst_quiet", {eff, en, busy, load_done, load_err}, 0);
    run_frame(8'h01, rnd_coef(), 1'b0, 0, -1, "after_rst");

    run_frame(8'h01, rnd_coef(), 1'b0, 0, 6, "edge_gap");

    for (int f = 0; f < 8; f++)
      run_frame(8'($urandom), rnd_coef(), ($urandom_range(0, 2) == 0), 3, -1, "rand");
    idle(1);
    check("final_no_pulse", {load_done, load_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
